// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame constants and parity helper.
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } state_t;

   localparam int DATA_BITS = 8;
   localparam int FE_PARITY = 9;
   localparam int FE_STOP   = 10;
   localparam int FE_ACK    = 11;

   typedef struct packed {
      logic [7:0] data;
      logic       parity;
   } tx_frame_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-flop synchronizer, FILTER_LEN-sample glitch filter and
// registered falling-edge pulse. Idle bus level is 1, so everything resets high.
module ps2_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic level,
   output logic fe
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b1;
         fe    <= 1'b0;
      end else begin
         sync <= {sync[0], pad};
         fe   <= 1'b0;
         // Any sample agreeing with the accepted level restarts the run.
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            cnt   <= '0;
            level <= sync[1];
            fe    <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start, 8 data, odd parity, stop, ack.
// Define PS2_TX_TIMEOUT_EN to build the watchdog covering SEND through WAIT_IDLE.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = 10000,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int FILTER_LEN  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err_timeout
);

   localparam int INH_W = $clog2(INHIBIT_CYC + 1);

   state_t           state, state_nx;
   logic [INH_W-1:0] inh_cnt, inh_cnt_nx;
   logic [3:0]       bit_cnt, bit_cnt_nx;
   tx_frame_t        frame, frame_nx;
   logic             done_nx, ack_ok_nx;
   logic [2:0]       bit_idx;

   logic clk_lvl, clk_fe, dat_lvl, unused_dat_fe;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .rst   (rst),
      .pad   (ps2_clk_in),
      .level (clk_lvl),
      .fe    (clk_fe)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk   (clk),
      .rst   (rst),
      .pad   (ps2_data_in),
      .level (dat_lvl),
      .fe    (unused_dat_fe)
   );

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd, wd_nx;
   logic            err_nx;
`else
   // Watchdog not built; expression is constant 0.
   assign err_timeout = (TIMEOUT_CYC < 0);
`endif

   always_comb begin
      state_nx   = state;
      inh_cnt_nx = inh_cnt;
      bit_cnt_nx = bit_cnt;
      frame_nx   = frame;
      ack_ok_nx  = ack_ok;
      done_nx    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_nx      = wd;
      err_nx     = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (tx_valid) begin
               frame_nx   = '{data: tx_data, parity: odd_parity(tx_data)};
               ack_ok_nx  = 1'b0;
               inh_cnt_nx = '0;
               state_nx   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) state_nx = ST_START;
            else                                     inh_cnt_nx = inh_cnt + 1'b1;
         end
         ST_START: begin
            bit_cnt_nx = '0;
            state_nx   = ST_SEND;
`ifdef PS2_TX_TIMEOUT_EN
            wd_nx      = '0;
`endif
         end
         ST_SEND: begin
            if (clk_fe) begin
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == 4'(FE_STOP - 1)) state_nx = ST_ACK;
            end
         end
         ST_ACK: begin
            if (clk_fe) begin
               ack_ok_nx  = ~dat_lvl;
               bit_cnt_nx = 4'(FE_ACK);
               state_nx   = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_lvl && dat_lvl) begin
               done_nx  = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Evaluated last so an expiry overrides a coincident fe 11.
      if (state inside {ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
         if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
            state_nx  = ST_IDLE;
            ack_ok_nx = 1'b0;
            done_nx   = 1'b1;
            err_nx    = 1'b1;
         end else begin
            wd_nx = wd + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         inh_cnt <= '0;
         bit_cnt <= '0;
         frame   <= '0;
         done    <= 1'b0;
         ack_ok  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd          <= '0;
         err_timeout <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         inh_cnt <= inh_cnt_nx;
         bit_cnt <= bit_cnt_nx;
         frame   <= frame_nx;
         done    <= done_nx;
         ack_ok  <= ack_ok_nx;
`ifdef PS2_TX_TIMEOUT_EN
         wd          <= wd_nx;
         err_timeout <= err_nx;
`endif
      end
   end

   // Line drive decoded from state; bit_cnt n means fe n has been seen.
   assign bit_idx = 3'(bit_cnt - 4'd1);

   always_comb begin
      ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_START);
      ps2_data_oe = 1'b0;
      case (state)
         ST_START: ps2_data_oe = 1'b1;
         ST_SEND: begin
            if (bit_cnt == 4'd0)                       ps2_data_oe = 1'b1;
            else if (bit_cnt <= 4'(DATA_BITS))         ps2_data_oe = ~frame.data[bit_idx];
            else if (bit_cnt == 4'(FE_PARITY))         ps2_data_oe = ~frame.parity;
         end
         default: ps2_data_oe = 1'b0;
      endcase
   end

   assign tx_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, for example 0xED followed by an LED mask, or 0xFF for reset. It complements the game's PS/2 keyboard receiver, which handles traffic in the opposite direction. The block sits between the game control logic and the open-drain PS/2 pads. It performs the full host request sequence: inhibit, start bit, eight data bits, odd parity, stop bit, and acknowledge check.

## Interface
Parameters:
- INHIBIT_CYC, 10000: cycles the clock line is held low before the start bit (100 µs at 100 MHz).
- TIMEOUT_CYC, 2000000: watchdog limit in cycles from clock release to acknowledge (20 ms at 100 MHz).
- FILTER_LEN, 4: consecutive equal synchronized samples required before a line level is accepted.

Ports:
- clk, in, 1: system clock. This is the only clock.
- rst, in, 1: synchronous, active-high reset.
- tx_data, in, 8: command byte to send.
- tx_valid, in, 1: request to send tx_data.
- tx_ready, out, 1: high only in IDLE. A byte is accepted when tx_valid and tx_ready are both high.
- ps2_clk_in, in, 1: raw PS/2 clock pad level (asynchronous).
- ps2_data_in, in, 1: raw PS/2 data pad level (asynchronous).
- ps2_clk_oe, out, 1: 1 = pull the PS/2 clock line low; 0 = release it.
- ps2_data_oe, out, 1: 1 = pull the PS/2 data line low; 0 = release it.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse when a transfer ends, whether it succeeds or fails.
- ack_ok, out, 1: held from done until the next accepted byte. 1 = the device acknowledged.
- err_timeout, out, 1: one-cycle pulse, coincident with done, when the watchdog expires.

## Operation
- Both PS/2 inputs pass through a 2-flop synchronizer and then a FILTER_LEN glitch filter.
- A falling edge (fe) is the filtered clock level changing from 1 to 0, marked for one cycle.
- On acceptance, tx_data is latched and an odd-parity bit is computed as ~^tx_data.
- The state sequence is IDLE → INHIBIT → START → SEND → ACK → WAIT_IDLE → IDLE.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0, for exactly INHIBIT_CYC cycles.
- START: lasts one cycle, with ps2_clk_oe=1 and ps2_data_oe=1. This places the start bit 0 on the line.
- SEND: ps2_clk_oe=0. A 4-bit bit counter starts at 0 and data remains driven low (start bit).
  - On fe number n, for n=1..8, the line carries bit n-1 of the byte, LSB first.
  - On fe 9 the line carries the parity bit.
  - On fe 10 the data line is released (stop bit = 1).
  - For every driven bit, ps2_data_oe = ~bit.
- ACK: on fe 11, sample the filtered data level. ack_ok = ~data. A low level means the device acknowledged.
- WAIT_IDLE: wait until the filtered clock and data levels are both 1. Then pulse done and return to IDLE.
- Watchdog:
  - Counts from entry to SEND.
  - Reaching TIMEOUT_CYC in SEND, ACK or WAIT_IDLE does the following in the same cycle: release both lines, set ack_ok=0, pulse err_timeout and done, go to IDLE.
- A tx_valid that arrives while busy is ignored, because tx_ready is 0.
- An fe seen during IDLE, INHIBIT or START is ignored.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_ok=0, err_timeout=0. The state is IDLE and all counters are 0.
- Reset in the middle of a transfer releases both lines on the next clock edge.
- tx_ready falls in the cycle after acceptance.
- ps2_clk_oe rises in that same cycle, and busy rises with it.
- The clock line is pulled low for INHIBIT_CYC+1 cycles in total, which includes the START cycle.
- Output response to a pad falling edge: 2 synchronizer cycles + FILTER_LEN cycles + 1 register stage.
- done occurs one cycle after both filtered lines are seen high in WAIT_IDLE.
- If the watchdog limit is reached in the same cycle as fe 11, the timeout takes precedence.

## Configuration
- PS2_TX_TIMEOUT_EN defined: the watchdog is implemented as described above.
- PS2_TX_TIMEOUT_EN undefined:
  - The watchdog logic is not built.
  - err_timeout is tied to 0.
  - A device that never clocks leaves the block in SEND until rst.

## Structure
- Shared package ps2_pkg holds:
  - the state encoding;
  - the PS/2 frame constants: DATA_BITS=8, FE_PARITY=9, FE_STOP=10, FE_ACK=11;
  - the parity function.
- The PS/2 keyboard receiver also uses ps2_pkg.
- One sub-module, ps2_line_filter, contains the synchronizer, glitch filter and falling-edge detect. It is instantiated once for clock and once for data, and is reused by the receiver.

## Test plan
- Send 0xED; the device model clocks at 12.5 kHz and acknowledges. Required: data line after fe1..fe10 is 1,0,1,1,0,1,1,1, then parity 1, then released. Then ack_ok=1 and one done pulse.
- Send 0x07 with no acknowledge (data high at fe 11). Required: parity bit 0, ack_ok=0, done pulse, err_timeout=0.
- Device model never clocks, with TIMEOUT_CYC=1000 and the macro defined. Required: err_timeout and done pulse 1000 cycles after SEND entry, both oe outputs 0, tx_ready=1.
- Assert rst in the middle of SEND after fe 5. Required: both oe outputs 0 and tx_ready=1 on the next edge. A following 0xFF sends with parity 1.
- Inject a 2-cycle glitch low on the PS/2 clock line during SEND with FILTER_LEN=4. Required: no bit advance, and the frame still completes correctly.
- Hold tx_valid high with 0x55 while busy. Required: exactly one transfer. A second transfer is accepted only after done.
